// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Purpose:
//   Two-port arbiter in front of a single data memory. Port 0 is the core
//   load/store port, port 1 is the DMA/debug port. In IDLE one requester is
//   granted combinationally. A legal write completes in its grant cycle. A
//   legal read strobes the memory in the grant cycle and returns data one
//   cycle later (RD_WAIT, no grants). An illegal access (misaligned or beyond
//   the last word) is granted without touching memory and answered with a
//   one-cycle err pulse in the following cycle.
//
// Handshake:
//   A requester raises pN_req with pN_we/pN_addr/pN_wdata and keeps all four
//   stable until it observes pN_gnt high. The request is consumed in the
//   grant cycle; the requester may drop or replace it from the next cycle.
//   Responses (pN_rvalid with pN_rdata, or pN_err) are single-cycle pulses
//   with no back-pressure.
//
// Configuration:
//   DMEM_ARB_RR_EN  defined   : round-robin arbitration on contention, using a
//                               1-bit last-grant register.
//                   undefined : fixed priority, port 0 always wins.
//
// Ports:
//   clk                        system clock, rising edge
//   rst                        asynchronous, active-high reset
//   p0_req/p0_we               port-0 request / write enable
//   p0_addr/p0_wdata [31:0]    port-0 byte address / store data
//   p0_gnt/p0_rvalid/p0_err    port-0 grant / read data valid / error pulse
//   p0_rdata [31:0]            port-0 read data (0 unless p0_rvalid)
//   p1_*                       same set for port 1
//   mem_write/mem_read         memory strobes (never both high)
//   mem_addr/mem_wdata [31:0]  memory address / write data (0 when idle)
//   mem_rdata [31:0]           memory read data, valid the cycle after mem_read
//
// Parameters:
//   MEM_BYTES                  memory size in bytes (default 4096)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int unsigned MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic        p0_err,
    output logic [31:0] p0_rdata,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic        p1_err,
    output logic [31:0] p1_rdata,

    output logic        mem_write,
    output logic        mem_read,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    // Highest address at which a full 32-bit word still fits in memory.
    localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;   // port that owns the outstanding read
    logic [1:0]  err_q,   err_d;     // per-port error pulse, bit index = port

`ifdef DMEM_ARB_RR_EN
    logic        last_q,  last_d;    // port granted most recently
`endif

    // -------------------------------------------------------------------------
    // Arbitration: pick the winning port index (only meaningful if any_req).
    // -------------------------------------------------------------------------
    logic        any_req;
    logic        sel;

    always_comb begin
        any_req = p0_req | p1_req;
`ifdef DMEM_ARB_RR_EN
        // On contention the port that was not granted last wins; otherwise
        // whichever port is requesting.
        if (p0_req && p1_req) begin
            sel = ~last_q;
        end else begin
            sel = ~p0_req;
        end
`else
        // Port 0 wins whenever it requests.
        sel = ~p0_req;
`endif
    end

    // Selected request fields.
    logic        s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic        s_legal;

    always_comb begin
        s_we    = sel ? p1_we    : p0_we;
        s_addr  = sel ? p1_addr  : p0_addr;
        s_wdata = sel ? p1_wdata : p0_wdata;
        s_legal = (s_addr[1:0] == 2'b00) && (s_addr <= LAST_WORD);
    end

    // -------------------------------------------------------------------------
    // FSM next state and outputs.
    // -------------------------------------------------------------------------
    logic        gnt0, gnt1;
    logic        rv0,  rv1;
    logic        wr_s, rd_s;
    logic [31:0] addr_s, wdata_s;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        err_d   = 2'b00;
`ifdef DMEM_ARB_RR_EN
        last_d  = last_q;
`endif
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        rv0     = 1'b0;
        rv1     = 1'b0;
        wr_s    = 1'b0;
        rd_s    = 1'b0;
        addr_s  = 32'd0;
        wdata_s = 32'd0;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt0 = ~sel;
                    gnt1 =  sel;
`ifdef DMEM_ARB_RR_EN
                    last_d = sel;
`endif
                    if (!s_legal) begin
                        // Granted but never reaches memory; error next cycle.
                        err_d[sel] = 1'b1;
                    end else if (s_we) begin
                        // Write completes in the grant cycle.
                        wr_s    = 1'b1;
                        addr_s  = s_addr;
                        wdata_s = s_wdata;
                    end else begin
                        rd_s    = 1'b1;
                        addr_s  = s_addr;
                        owner_d = sel;
                        state_d = RD_WAIT;
                    end
                end
            end

            RD_WAIT: begin
                // Memory data for the read issued last cycle is on mem_rdata.
                rv0     = ~owner_q;
                rv1     =  owner_q;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset silences every combinational output immediately, without
        // waiting for the state register to settle.
        if (rst) begin
            gnt0    = 1'b0;
            gnt1    = 1'b0;
            rv0     = 1'b0;
            rv1     = 1'b0;
            wr_s    = 1'b0;
            rd_s    = 1'b0;
            addr_s  = 32'd0;
            wdata_s = 32'd0;
        end
    end

    // -------------------------------------------------------------------------
    // State registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            err_q   <= err_d;
        end
    end

`ifdef DMEM_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Output assignments.
    // -------------------------------------------------------------------------
    assign p0_gnt    = gnt0;
    assign p1_gnt    = gnt1;
    assign p0_rvalid = rv0;
    assign p1_rvalid = rv1;
    assign p0_rdata  = rv0 ? mem_rdata : 32'd0;
    assign p1_rdata  = rv1 ? mem_rdata : 32'd0;
    assign p0_err    = err_q[0];
    assign p1_err    = err_q[1];

    assign mem_write = wr_s;
    assign mem_read  = rd_s;
    assign mem_addr  = addr_s;
    assign mem_wdata = wdata_s;

    // -------------------------------------------------------------------------
    // Structural properties.
    // -------------------------------------------------------------------------
    a_strobe_excl : assert property (@(posedge clk) disable iff (rst)
        !(mem_write && mem_read));
    a_gnt_onehot  : assert property (@(posedge clk) disable iff (rst)
        !(p0_gnt && p1_gnt));
    a_no_gnt_wait : assert property (@(posedge clk) disable iff (rst)
        (state_q == RD_WAIT) |-> !(p0_gnt || p1_gnt));

endmodule
